// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin arbiter and sequencer for the shared
// byte-addressed data memory.
//
// Port 0 (fetch) issues implicit word reads. Port 1 (load/store) uses RISC-V
// funct3 encoding. One request is granted at a time. A legal request holds the
// memory controls stable for MEM_LAT cycles, then returns a one-cycle response
// to its owner. Out-of-range or malformed requests are answered with an error
// and never reach the memory.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req0_valid/addr/ready    fetch request handshake
//   rsp0_valid/data/err      fetch response pulse
//   req1_valid/write/funct3/addr/wdata/ready   load/store request handshake
//   rsp1_valid/data/err      load/store response pulse (also the store ack)
//   MemRead, MemWrite, funct3, memAddr, writeData_M   memory controls
//   readData_M               memory read data, sampled on the last held cycle
module mem_port_arbiter #(
    parameter int unsigned MEM_SIZE = 2048,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp0_err,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [2:0]  req1_funct3,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic        rsp1_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  funct3,
    output logic [31:0] memAddr,
    output logic [31:0] writeData_M,
    input  logic [31:0] readData_M
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic        is_write_q, is_write_d;
    logic        err_q, err_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        accept;
    logic        gnt;          // 0 = port 0, 1 = port 1
    logic        sel_write;
    logic [2:0]  sel_f3;
    logic [31:0] sel_addr;
    logic [2:0]  sel_bytes;
    logic [32:0] sel_end;
    logic        sel_err;

    // Arbitration and legality check of the candidate request.
    always_comb begin
        accept    = (state_q == StIdle) && (req0_valid || req1_valid);
        gnt       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        sel_write = gnt ? req1_write : 1'b0;
        sel_f3    = gnt ? req1_funct3 : 3'd2;
        sel_addr  = gnt ? req1_addr : req0_addr;
        case (sel_f3)
            3'd0, 3'd4: sel_bytes = 3'd1;
            3'd1, 3'd5: sel_bytes = 3'd2;
            default:    sel_bytes = 3'd4;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        sel_end = {1'b0, sel_addr} + {30'd0, sel_bytes};
        sel_err = (sel_end > 33'(MEM_SIZE))
               || (sel_write  && (sel_f3 > 3'd2))
               || (!sel_write && ((sel_f3 == 3'd3) || (sel_f3 >= 3'd6)));
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        is_write_d   = is_write_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    owner_d      = gnt;
                    last_grant_d = gnt;
                    is_write_d   = sel_write;
                    err_d        = sel_err;
                    rdata_d      = '0;
                    if (sel_err) begin
                        state_d = StResp;
                    end else begin
                        // Memory-facing registers change only for legal
                        // requests so the bus stays quiet across errors.
                        state_d = StBusy;
                        cnt_d   = 3'(MEM_LAT - 1);
                        f3_d    = sel_f3;
                        addr_d  = sel_addr;
                        if (gnt) begin
                            wdata_d = req1_wdata;
                        end
                    end
                end
            end
            StBusy: begin
                if (cnt_q == 3'd0) begin
                    state_d = StResp;
                    if (!is_write_q) begin
                        rdata_d = readData_M;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            is_write_q   <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            is_write_q   <= is_write_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        req0_ready  = accept && !gnt;
        req1_ready  = accept && gnt;
        MemRead     = (state_q == StBusy) && !is_write_q;
        MemWrite    = (state_q == StBusy) && is_write_q;
        funct3      = f3_q;
        memAddr     = addr_q;
        writeData_M = wdata_q;
        rsp0_valid  = (state_q == StResp) && !owner_q;
        rsp1_valid  = (state_q == StResp) && owner_q;
        rsp0_err    = rsp0_valid && err_q;
        rsp1_err    = rsp1_valid && err_q;
        rsp0_data   = rsp0_valid ? rdata_q : '0;
        rsp1_data   = rsp1_valid ? rdata_q : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with
// MEM_SIZE=2048 and MEM_LAT=1. A combinational memory model returns
// 0xDEADBEEF at 0x10 and {addr[15:0], 16'hC0DE} elsewhere.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_addr = '0;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [31:0] rsp0_data;
    logic        rsp0_err;
    logic        req1_valid = 1'b0;
    logic        req1_write = 1'b0;
    logic [2:0]  req1_funct3 = '0;
    logic [31:0] req1_addr = '0;
    logic [31:0] req1_wdata = '0;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [31:0] rsp1_data;
    logic        rsp1_err;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] memAddr;
    logic [31:0] writeData_M;
    logic [31:0] readData_M;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign readData_M = (memAddr == 32'h10) ? 32'hDEADBEEF : {memAddr[15:0], 16'hC0DE};

    mem_port_arbiter #(
        .MEM_SIZE(2048),
        .MEM_LAT (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_funct3(req1_funct3),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_err   (rsp1_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .memAddr    (memAddr),
        .writeData_M(writeData_M),
        .readData_M (readData_M)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Present a request for one cycle, check it is accepted, then drop valid.
    // Returns #1 into the first cycle after the accepting edge.
    task automatic issue0(input string tag, input logic [31:0] a);
        @(negedge clk);
        req0_valid = 1'b1;
        req0_addr  = a;
        #1;
        check_eq({tag, "_ready"}, 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
    endtask

    task automatic issue1(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req1_valid  = 1'b1;
        req1_write  = w;
        req1_funct3 = f3;
        req1_addr   = a;
        req1_wdata  = d;
        #1;
        check_eq({tag, "_ready"}, 32'(req1_ready), 32'd1);
        check_eq({tag, "_ready0"}, 32'(req0_ready), 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
    endtask

    task automatic expect_err1(input string tag);
        check_eq({tag, "_valid"}, 32'(rsp1_valid), 32'd1);
        check_eq({tag, "_err"}, 32'(rsp1_err), 32'd1);
        check_eq({tag, "_data"}, rsp1_data, 32'd0);
        check_eq({tag, "_memrd"}, 32'(MemRead), 32'd0);
        check_eq({tag, "_memwr"}, 32'(MemWrite), 32'd0);
        next_cyc();
        check_eq({tag, "_done"}, 32'(rsp1_valid), 32'd0);
    endtask

    initial begin
        int pulses;

        // Reset state.
        do_reset();
        check_eq("rst_memrd", 32'(MemRead), 32'd0);
        check_eq("rst_memwr", 32'(MemWrite), 32'd0);
        check_eq("rst_rsp0", 32'(rsp0_valid), 32'd0);
        check_eq("rst_rsp1", 32'(rsp1_valid), 32'd0);
        check_eq("rst_addr", memAddr, 32'd0);
        check_eq("rst_f3", 32'(funct3), 32'd0);

        // Single fetch; valid dropped right after acceptance.
        issue0("f0", 32'h10);
        check_eq("f0_memrd", 32'(MemRead), 32'd1);
        check_eq("f0_addr", memAddr, 32'h10);
        check_eq("f0_f3", 32'(funct3), 32'd2);
        check_eq("f0_early", 32'(rsp0_valid), 32'd0);
        next_cyc();
        check_eq("f0_valid", 32'(rsp0_valid), 32'd1);
        check_eq("f0_data", rsp0_data, 32'hDEADBEEF);
        check_eq("f0_err", 32'(rsp0_err), 32'd0);
        check_eq("f0_rsp1", 32'(rsp1_valid), 32'd0);
        check_eq("f0_memrd_off", 32'(MemRead), 32'd0);
        next_cyc();
        check_eq("f0_once", 32'(rsp0_valid), 32'd0);
        check_eq("f0_hold_addr", memAddr, 32'h10);

        // Store halfword.
        issue1("st", 1'b1, 3'd1, 32'h20, 32'h1234ABCD);
        check_eq("st_memwr", 32'(MemWrite), 32'd1);
        check_eq("st_memrd", 32'(MemRead), 32'd0);
        check_eq("st_wdata", writeData_M, 32'h1234ABCD);
        check_eq("st_f3", 32'(funct3), 32'd1);
        check_eq("st_addr", memAddr, 32'h20);
        next_cyc();
        check_eq("st_valid", 32'(rsp1_valid), 32'd1);
        check_eq("st_data", rsp1_data, 32'd0);
        check_eq("st_err", 32'(rsp1_err), 32'd0);
        check_eq("st_memwr_off", 32'(MemWrite), 32'd0);
        check_eq("st_memrd_off", 32'(MemRead), 32'd0);

        // Error cases: memory never enabled, bus held.
        issue1("e_range", 1'b0, 3'd2, 32'h7FE, 32'd0);
        check_eq("e_range_hold", memAddr, 32'h20);
        expect_err1("e_range");
        issue1("e_lhu", 1'b0, 3'd5, 32'h7FF, 32'd0);
        expect_err1("e_lhu");
        issue1("e_ld3", 1'b0, 3'd3, 32'h40, 32'd0);
        expect_err1("e_ld3");
        issue1("e_st4", 1'b1, 3'd4, 32'h40, 32'd0);
        expect_err1("e_st4");
        issue0("e_wrap", 32'hFFFFFFFE);
        check_eq("e_wrap_valid", 32'(rsp0_valid), 32'd1);
        check_eq("e_wrap_err", 32'(rsp0_err), 32'd1);
        check_eq("e_wrap_data", rsp0_data, 32'd0);
        check_eq("e_wrap_memrd", 32'(MemRead), 32'd0);
        check_eq("e_wrap_hold", memAddr, 32'h20);
        next_cyc();

        // Legal boundary loads.
        issue1("b_lw", 1'b0, 3'd2, 32'h7FC, 32'd0);
        check_eq("b_lw_memrd", 32'(MemRead), 32'd1);
        next_cyc();
        check_eq("b_lw_valid", 32'(rsp1_valid), 32'd1);
        check_eq("b_lw_err", 32'(rsp1_err), 32'd0);
        check_eq("b_lw_data", rsp1_data, 32'h07FCC0DE);
        issue1("b_lbu", 1'b0, 3'd4, 32'h7FF, 32'd0);
        check_eq("b_lbu_f3", 32'(funct3), 32'd4);
        next_cyc();
        check_eq("b_lbu_err", 32'(rsp1_err), 32'd0);
        check_eq("b_lbu_data", rsp1_data, 32'h07FFC0DE);

        // Round-robin from reset with both ports requesting continuously.
        do_reset();
        req0_addr   = 32'h10;
        req1_write  = 1'b0;
        req1_funct3 = 3'd2;
        req1_addr   = 32'h100;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            #1;
            check_eq($sformatf("rr%0d_rdy0", c), 32'(req0_ready), 32'((c % 6) == 0));
            check_eq($sformatf("rr%0d_rdy1", c), 32'(req1_ready), 32'((c % 6) == 3));
            check_eq($sformatf("rr%0d_rsp0", c), 32'(rsp0_valid), 32'((c % 6) == 2));
            check_eq($sformatf("rr%0d_rsp1", c), 32'(rsp1_valid), 32'((c % 6) == 5));
            if (c == 2) check_eq("rr_d0", rsp0_data, 32'hDEADBEEF);
            if (c == 5) check_eq("rr_d1", rsp1_data, 32'h0100C0DE);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;

        // Reset during BUSY of a fetch (last grant was port 0).
        issue0("ab", 32'h10);
        check_eq("ab_memrd", 32'(MemRead), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("ab_memrd_off", 32'(MemRead), 32'd0);
        check_eq("ab_no_rsp0", 32'(rsp0_valid), 32'd0);
        next_cyc();
        check_eq("ab_no_rsp0_b", 32'(rsp0_valid), 32'd0);
        check_eq("ab_no_rsp1", 32'(rsp1_valid), 32'd0);
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_eq("ab_tie_rdy0", 32'(req0_ready), 32'd1);
        check_eq("ab_tie_rdy1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        next_cyc();
        check_eq("ab_tie_rsp0", 32'(rsp0_valid), 32'd1);
        check_eq("ab_tie_data", rsp0_data, 32'hDEADBEEF);
        next_cyc();

        // Valid dropped right after acceptance: exactly one response.
        issue1("drop", 1'b0, 3'd0, 32'h40, 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp1_valid) begin
                pulses++;
                check_eq("drop_data", rsp1_data, 32'h0040C0DE);
            end
            next_cyc();
        end
        check_eq("drop_pulses", 32'(pulses), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
